// File: rtl/pc_branch_ctrl_pkg.sv
// pc_ctrl_pkg: shared encodings for the PC / branch controller.
//   br_mode encodings, exception cause codes and FSM state constants.
package pc_ctrl_pkg;

    localparam logic [2:0] BR_EQ     = 3'd0;
    localparam logic [2:0] BR_NE     = 3'd1;
    localparam logic [2:0] BR_GT     = 3'd2;
    localparam logic [2:0] BR_LE     = 3'd3;
    localparam logic [2:0] BR_LT     = 3'd4;
    localparam logic [2:0] BR_GE     = 3'd5;
    localparam logic [2:0] BR_ALWAYS = 3'd6;
    localparam logic [2:0] BR_NEVER  = 3'd7;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_EXT   = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_EXC = 1'b1;

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if: request/response bundle between the control unit
// (master) and pc_branch_ctrl (slave).
//   master drives: stall, pc_write, pc_write_cond, br_mode, src_a, src_b,
//                  next_pc_in, exc_req, eret
//   slave drives:  pc_out, epc_out, pc_we, cond_met, taken, exc_cause,
//                  in_exc, taken_count
interface pc_branch_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              pc_write;
    logic              pc_write_cond;
    logic [2:0]        br_mode;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] next_pc_in;
    logic              exc_req;
    logic              eret;

    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] epc_out;
    logic              pc_we;
    logic              cond_met;
    logic              taken;
    logic [1:0]        exc_cause;
    logic              in_exc;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output stall, pc_write, pc_write_cond, br_mode, src_a, src_b,
               next_pc_in, exc_req, eret,
        input  pc_out, epc_out, pc_we, cond_met, taken, exc_cause,
               in_exc, taken_count
    );

    modport slave (
        input  stall, pc_write, pc_write_cond, br_mode, src_a, src_b,
               next_pc_in, exc_req, eret,
        output pc_out, epc_out, pc_we, cond_met, taken, exc_cause,
               in_exc, taken_count
    );
endinterface

// File: rtl/pc_branch_ctrl_branch_cond.sv
// branch_cond: combinational branch condition evaluator.
//   a, b : operands; mode : br_mode select; met : condition true.
//   SIGNED_CMP selects signed or unsigned ordering for GT/LE/LT/GE.
module branch_cond
    import pc_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        mode,
    output logic              met
);
    logic eq, gt, lt;

    assign eq = (a == b);

    if (SIGNED_CMP) begin : g_signed
        assign gt = $signed(a) > $signed(b);
        assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
        assign gt = a > b;
        assign lt = a < b;
    end

    // LE/GE are the complements of GT/LT
    always_comb begin
        met = 1'b0;
        case (mode)
            BR_EQ:     met = eq;
            BR_NE:     met = ~eq;
            BR_GT:     met = gt;
            BR_LE:     met = ~gt;
            BR_LT:     met = lt;
            BR_GE:     met = ~lt;
            BR_ALWAYS: met = 1'b1;
            default:   met = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: owns the PC and EPC, evaluates the branch condition,
// enters/leaves exceptions and counts taken conditional branches.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pc_branch_ctrl_if slave (control inputs, PC/status outputs)
module pc_branch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter bit                SIGNED_CMP = 1'b1,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'('hFD),
    parameter int                EXC_LAT    = 2,
    parameter int                CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    pc_branch_ctrl_if.slave bus
);
    localparam int HOLD_W = (EXC_LAT > 1) ? $clog2(EXC_LAT) : 1;

    logic [DATA_W-1:0] pc_q, pc_d, epc_q, epc_d;
    logic              taken_q, taken_d;
    logic [1:0]        cause_q, cause_d;
    logic [0:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic cond_met, req, misalign, run, br_taken;

    branch_cond #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cond (
        .a    (bus.src_a),
        .b    (bus.src_b),
        .mode (bus.br_mode),
        .met  (cond_met)
    );

    assign run      = (state_q == ST_RUN);
    assign req      = bus.pc_write | (bus.pc_write_cond & cond_met);
    assign misalign = req & (bus.next_pc_in[1:0] != 2'b00);
    assign bus.pc_we = req & ~misalign & ~bus.exc_req & ~bus.eret & ~bus.stall & run;
    // a counted branch is exactly a PC write driven by a true condition
    assign br_taken = bus.pc_write_cond & cond_met & bus.pc_we;

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        taken_d = taken_q;
        cause_d = cause_q;
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            taken_d = br_taken;
            if (br_taken && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
            if (run) begin
                if (bus.exc_req || misalign) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    cause_d = bus.exc_req ? CAUSE_EXT : CAUSE_ALIGN;
                    state_d = ST_EXC;
                    hold_d  = HOLD_W'(EXC_LAT - 1);
                end else if (bus.eret) begin
                    pc_d    = epc_q;
                    cause_d = CAUSE_NONE;
                end else if (req) begin
                    pc_d = bus.next_pc_in;
                end
            end else begin
                // hold counter reaching zero marks the last EXC cycle
                if (hold_q == '0)
                    state_d = ST_RUN;
                else
                    hold_d = hold_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            taken_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            state_q <= ST_RUN;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            taken_q <= taken_d;
            cause_q <= cause_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.epc_out     = epc_q;
    assign bus.cond_met    = cond_met;
    assign bus.taken       = taken_q;
    assign bus.exc_cause   = cause_q;
    assign bus.in_exc      = (state_q == ST_EXC);
    assign bus.taken_count = cnt_q;
endmodule
